// File: rtl/scontrol_pkg.sv
// Shared types and step-list helpers for the scontrol command driver.
// A request is expanded into a fixed list of 3-bit command codes.
package scontrol_pkg;

   localparam int unsigned C_W    = 3;
   localparam int unsigned OP_W   = 2;
   localparam int unsigned STEP_W = 3;

   typedef enum logic [C_W-1:0] {
      CMD_PAUSE     = 3'd0,
      CMD_PLUS      = 3'd1,
      CMD_MINUS     = 3'd2,
      CMD_BALLAST_P = 3'd3,
      CMD_BALLAST_N = 3'd4,
      CMD_START     = 3'd5,
      CMD_SHUTDOWN  = 3'd6,
      CMD_DISCHARGE = 3'd7
   } cmd_e;

   typedef enum logic [OP_W-1:0] {
      OP_SINGLE    = 2'd0,
      OP_START     = 2'd1,
      OP_DISCHARGE = 2'd2,
      OP_RSVD      = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SETUP = 3'd2,
      ST_HIGH  = 3'd3,
      ST_LOW   = 3'd4
   } state_e;

   // Code driven on C[2:0] for a given step of a request.
   function automatic logic [C_W-1:0] step_code(input op_e op, input logic [C_W-1:0] arg,
                                                input logic [STEP_W-1:0] step);
      logic [C_W-1:0] code;
      code = arg;
      case (op)
         OP_START:     code = (step == 3'd0) ? C_W'(CMD_START) : C_W'(CMD_PAUSE);
         OP_DISCHARGE: begin
            case (step)
               3'd0, 3'd2: code = C_W'(CMD_DISCHARGE);
               3'd1, 3'd3: code = C_W'(CMD_PAUSE);
               default:    code = arg;
            endcase
         end
         default:      code = arg;
      endcase
      return code;
   endfunction

   function automatic logic [STEP_W-1:0] step_len(input op_e op);
      logic [STEP_W-1:0] len;
      case (op)
         OP_START:     len = 3'd2;
         OP_DISCHARGE: len = 3'd5;
         default:      len = 3'd1;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/scontrol_cmd_driver_if.sv
// Request handshake and C/CLK pin bundle between supervisor and command driver.
interface scontrol_cmd_driver_if;
   import scontrol_pkg::*;

   logic             req_valid;
   logic             req_ready;
   logic [OP_W-1:0]  req_op;
   logic [C_W-1:0]   req_arg;
   logic             abort;
   logic [C_W-1:0]   o_c;
   logic             o_clk;
   logic             busy;
   logic             done;
   logic             err;

   modport master (
      output req_valid, req_op, req_arg, abort,
      input  req_ready, o_c, o_clk, busy, done, err
   );

   modport slave (
      input  req_valid, req_op, req_arg, abort,
      output req_ready, o_c, o_clk, busy, done, err
   );

endinterface

// File: rtl/scontrol_phase_timer.sv
// Down-counter timing one strobe phase: load N-1, expire_c high on the Nth cycle.
module scontrol_phase_timer #(
   parameter int unsigned W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] load_val,
   output logic         expire_c
);

   logic [W-1:0] cnt_q, cnt_d;
   logic         run_q, run_d;

   always_comb begin
      cnt_d = cnt_q;
      run_d = run_q;
      if (start) begin
         cnt_d = load_val;
         run_d = 1'b1;
      end else if (run_q) begin
         if (cnt_q == '0) run_d = 1'b0;
         else             cnt_d = cnt_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign expire_c = run_q && (cnt_q == '0);

endmodule

// File: rtl/scontrol_cmd_driver.sv
// Host-side initiator for the scontrol C[2:0]/CLK bus: expands requests into
// timed strobes (setup, high, low/hold) and reports completion via done/err.
module scontrol_cmd_driver
   import scontrol_pkg::*;
#(
   parameter int unsigned FREQ      = 50000,
   parameter int unsigned SETUP_CYC = 2,
   parameter int unsigned HIGH_US   = 1,
   parameter int unsigned LOW_US    = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   scontrol_cmd_driver_if.slave bus
);

   localparam int unsigned HIGH_CYC = FREQ * HIGH_US / 1000;
   localparam int unsigned LOW_CYC  = FREQ * LOW_US / 1000;
   localparam int unsigned MAX_SH   = (SETUP_CYC > HIGH_CYC) ? SETUP_CYC : HIGH_CYC;
   localparam int unsigned MAX_CYC  = (MAX_SH > LOW_CYC) ? MAX_SH : LOW_CYC;
   localparam int unsigned TW       = $clog2(MAX_CYC + 1);

   state_e              state_q, state_d;
   op_e                 op_q, op_d;
   logic [C_W-1:0]      arg_q, arg_d;
   logic [C_W-1:0]      o_c_q, o_c_d;
   logic [STEP_W-1:0]   step_q, step_d;
   logic                o_clk_q, o_clk_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                abort_pend_q, abort_pend_d;
   logic                rsvd_pend_q, rsvd_pend_d;
   logic                tmr_start;
   logic [TW-1:0]       tmr_load;
   logic                tmr_expire_c;
   logic                busy_c;
   logic                abort_eff_c;

   scontrol_phase_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (tmr_start),
      .load_val (tmr_load),
      .expire_c (tmr_expire_c)
   );

   assign busy_c      = (state_q != ST_IDLE);
   assign abort_eff_c = abort_pend_q | bus.abort;

   // Next-state and output logic; the strobe in flight always finishes before abort takes effect.
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      arg_d        = arg_q;
      o_c_d        = o_c_q;
      step_d       = step_q;
      o_clk_d      = o_clk_q;
      done_d       = 1'b0;
      err_d        = 1'b0;
      abort_pend_d = abort_pend_q | (bus.abort & busy_c);
      rsvd_pend_d  = 1'b0;
      tmr_start    = 1'b0;
      tmr_load     = '0;

      case (state_q)
         ST_IDLE: begin
            abort_pend_d = 1'b0;
            if (rsvd_pend_q) begin
               done_d = 1'b1;
               err_d  = 1'b1;
            end
            if (bus.req_valid) begin
               op_d   = op_e'(bus.req_op);
               arg_d  = bus.req_arg;
               step_d = '0;
               if (op_e'(bus.req_op) == OP_RSVD) rsvd_pend_d = 1'b1;
               else                              state_d     = ST_LOAD;
            end
         end
         ST_LOAD: begin
            o_c_d     = step_code(op_q, arg_q, step_q);
            state_d   = ST_SETUP;
            tmr_start = 1'b1;
            tmr_load  = TW'(SETUP_CYC - 1);
         end
         ST_SETUP: begin
            if (tmr_expire_c) begin
               o_clk_d   = 1'b1;
               state_d   = ST_HIGH;
               tmr_start = 1'b1;
               tmr_load  = TW'(HIGH_CYC - 1);
            end
         end
         ST_HIGH: begin
            if (tmr_expire_c) begin
               o_clk_d   = 1'b0;
               state_d   = ST_LOW;
               tmr_start = 1'b1;
               tmr_load  = TW'(LOW_CYC - 1);
            end
         end
         ST_LOW: begin
            if (tmr_expire_c) begin
               if ((step_q == step_len(op_q) - STEP_W'(1)) || abort_eff_c) begin
                  state_d      = ST_IDLE;
                  done_d       = 1'b1;
                  err_d        = abort_eff_c;
                  abort_pend_d = 1'b0;
               end else begin
                  step_d    = step_q + STEP_W'(1);
                  o_c_d     = step_code(op_q, arg_q, step_d);
                  state_d   = ST_SETUP;
                  tmr_start = 1'b1;
                  tmr_load  = TW'(SETUP_CYC - 1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         op_q         <= OP_SINGLE;
         arg_q        <= '0;
         o_c_q        <= '0;
         step_q       <= '0;
         o_clk_q      <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         abort_pend_q <= 1'b0;
         rsvd_pend_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         arg_q        <= arg_d;
         o_c_q        <= o_c_d;
         step_q       <= step_d;
         o_clk_q      <= o_clk_d;
         done_q       <= done_d;
         err_q        <= err_d;
         abort_pend_q <= abort_pend_d;
         rsvd_pend_q  <= rsvd_pend_d;
      end
   end

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.o_c       = o_c_q;
   assign bus.o_clk     = o_clk_q;
   assign bus.busy      = busy_c;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_scontrol_cmd_driver.sv
// Bench for scontrol_cmd_driver: timeline model of each request checked every
// cycle, plus literal expectations at key cycles of each scenario.
module tb_scontrol_cmd_driver;

   localparam int SETUP  = 2;
   localparam int HIGH   = 50;
   localparam int LOW    = 50;
   localparam int STROBE = SETUP + HIGH + LOW;

   logic clk;
   logic rst_n;
   int   cyc;
   int   total;
   int   bad;
   bit   check_en;

   scontrol_cmd_driver_if bus_if ();

   scontrol_cmd_driver #(
      .FREQ(50000), .SETUP_CYC(2), .HIGH_US(1), .LOW_US(1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Current request as a timeline: accept edge t0, n strobes of the code list.
   int         t0;
   int         n;
   int         t_free;
   bit         active;
   bit         rsvd;
   bit         aborted;
   logic [2:0] codes [5];
   logic [2:0] prev_oc;

   function automatic void model(input int t, output logic [2:0] oc, output bit ck,
                                 output bit bsy, output bit dn, output bit er, output bit rdy);
      int tdone;
      int k;
      int ph;
      oc = prev_oc; ck = 0; bsy = 0; dn = 0; er = 0;
      if (active) begin
         if (rsvd) begin
            dn = (t == t0 + 1);
            er = dn;
         end else begin
            tdone = t0 + 1 + STROBE * n;
            bsy   = (t >= t0) && (t < tdone);
            dn    = (t == tdone);
            er    = dn && aborted;
            if (t >= t0 + 1) begin
               k = (t - t0 - 1) / STROBE;
               if (k > n - 1) k = n - 1;
               oc = codes[k];
            end
            if (bsy && t >= t0 + 1) begin
               ph = (t - t0 - 1) % STROBE;
               ck = (ph >= SETUP) && (ph < SETUP + HIGH);
            end
         end
      end
      rdy = !bsy;
   endfunction

   task automatic chk(input string nm, input int act, input int exp_v);
      total++;
      if (act != exp_v) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp_v);
      end
   endtask

   logic [2:0] e_oc;
   bit         e_ck, e_bsy, e_dn, e_er, e_rdy;

   always @(negedge clk) begin
      if (check_en) begin
         model(cyc, e_oc, e_ck, e_bsy, e_dn, e_er, e_rdy);
         chk("cyc_o_c",   int'(bus_if.o_c),       int'(e_oc));
         chk("cyc_o_clk", int'(bus_if.o_clk),     int'(e_ck));
         chk("cyc_busy",  int'(bus_if.busy),      int'(e_bsy));
         chk("cyc_done",  int'(bus_if.done),      int'(e_dn));
         chk("cyc_err",   int'(bus_if.err),       int'(e_er));
         chk("cyc_ready", int'(bus_if.req_ready), int'(e_rdy));
      end
   end

   task automatic at_cycle(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic send(input int op, input int arg);
      logic [2:0] poc;
      bit d1, d2, d3, d4, d5;
      while (cyc < t_free) @(negedge clk);
      bus_if.req_op    = 2'(op);
      bus_if.req_arg   = 3'(arg);
      bus_if.req_valid = 1'b1;
      @(posedge clk);
      #1;
      model(cyc, poc, d1, d2, d3, d4, d5);
      prev_oc = poc;
      t0      = cyc;
      active  = 1;
      aborted = 0;
      rsvd    = (op == 3);
      case (op)
         0: begin codes[0] = 3'(arg); n = 1; end
         1: begin codes[0] = 3'd5; codes[1] = 3'd0; n = 2; end
         2: begin
            codes[0] = 3'd7; codes[1] = 3'd0; codes[2] = 3'd7; codes[3] = 3'd0;
            codes[4] = 3'(arg); n = 5;
         end
         default: n = 0;
      endcase
      t_free = rsvd ? t0 + 1 : t0 + 1 + STROBE * n;
      bus_if.req_valid = 1'b0;
   endtask

   task automatic abort_at(input int t);
      logic [2:0] oc;
      bit ck, bsy, dn, er, rdy;
      int ta;
      int k;
      at_cycle(t);
      bus_if.abort = 1'b1;
      @(posedge clk);
      #1;
      ta = cyc;
      bus_if.abort = 1'b0;
      model(ta - 1, oc, ck, bsy, dn, er, rdy);
      if (bsy) begin
         aborted = 1;
         k = (ta - t0 - 2) / STROBE;
         if (k < 0) k = 0;
         if (k + 1 < n) n = k + 1;
         t_free = t0 + 1 + STROBE * n;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int ts;
      total = 0; bad = 0; check_en = 0;
      active = 0; rsvd = 0; aborted = 0; prev_oc = 3'd0; n = 0; t0 = 0; t_free = 0;
      bus_if.req_valid = 1'b0; bus_if.req_op = 2'd0; bus_if.req_arg = 3'd0; bus_if.abort = 1'b0;
      rst_n = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_o_c",   int'(bus_if.o_c), 0);
      chk("rst_o_clk", int'(bus_if.o_clk), 0);
      chk("rst_busy",  int'(bus_if.busy), 0);
      chk("rst_done",  int'(bus_if.done), 0);
      chk("rst_err",   int'(bus_if.err), 0);
      chk("rst_ready", int'(bus_if.req_ready), 1);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_en = 1;
      t_free = cyc;

      // SINGLE arg=1
      send(0, 1);
      ts = t0;
      chk("single_busy_t0",  int'(bus_if.busy), 1);
      chk("single_ready_t0", int'(bus_if.req_ready), 0);
      at_cycle(ts + 1);  chk("single_oc_t1",   int'(bus_if.o_c), 1);
      at_cycle(ts + 2);  chk("single_clk_t2",  int'(bus_if.o_clk), 0);
      at_cycle(ts + 3);  chk("single_clk_t3",  int'(bus_if.o_clk), 1);
      at_cycle(ts + 52); chk("single_clk_t52", int'(bus_if.o_clk), 1);
      at_cycle(ts + 53); chk("single_clk_t53", int'(bus_if.o_clk), 0);
      at_cycle(ts + 102); chk("single_done_t102", int'(bus_if.done), 0);
      at_cycle(ts + 103);
      chk("single_done_t103", int'(bus_if.done), 1);
      chk("single_err_t103",  int'(bus_if.err), 0);
      chk("single_ready_t103", int'(bus_if.req_ready), 1);

      // START: 5 then 0
      send(1, 0);
      ts = t0;
      chk("start_accept_right_after_done", ts, t0);
      at_cycle(ts + 1);   chk("start_oc_first",  int'(bus_if.o_c), 5);
      at_cycle(ts + 103); chk("start_oc_second", int'(bus_if.o_c), 0);
      at_cycle(ts + 105); chk("start_clk_second", int'(bus_if.o_clk), 1);
      at_cycle(ts + 205);
      chk("start_done", int'(bus_if.done), 1);
      chk("start_err",  int'(bus_if.err), 0);

      // DISCHARGE arg=3: 7,0,7,0,3
      send(2, 3);
      ts = t0;
      at_cycle(ts + 1 + 2 * STROBE + 10); chk("dis_oc_step2", int'(bus_if.o_c), 7);
      at_cycle(ts + 1 + 4 * STROBE + 10); chk("dis_oc_step4", int'(bus_if.o_c), 3);
      at_cycle(ts + 1 + 4 * STROBE + 20); chk("dis_ready_last", int'(bus_if.req_ready), 0);
      at_cycle(ts + 511);
      chk("dis_done", int'(bus_if.done), 1);
      chk("dis_err",  int'(bus_if.err), 0);

      // DISCHARGE arg=6 aborted during the second strobe HIGH
      send(2, 6);
      ts = t0;
      abort_at(ts + 120);
      at_cycle(ts + 154); chk("abort_clk_full_high", int'(bus_if.o_clk), 1);
      at_cycle(ts + 155); chk("abort_clk_fall",      int'(bus_if.o_clk), 0);
      at_cycle(ts + 205);
      chk("abort_done", int'(bus_if.done), 1);
      chk("abort_err",  int'(bus_if.err), 1);
      chk("abort_oc_hold", int'(bus_if.o_c), 0);
      at_cycle(ts + 215); chk("abort_no_third", int'(bus_if.o_clk), 0);

      // SINGLE after abort
      send(0, 2);
      ts = t0;
      at_cycle(ts + 103);
      chk("post_abort_done", int'(bus_if.done), 1);
      chk("post_abort_err",  int'(bus_if.err), 0);

      // reserved op
      send(3, 5);
      ts = t0;
      chk("rsvd_ready_t0", int'(bus_if.req_ready), 1);
      chk("rsvd_done_t0",  int'(bus_if.done), 0);
      at_cycle(ts + 1);
      chk("rsvd_done", int'(bus_if.done), 1);
      chk("rsvd_err",  int'(bus_if.err), 1);
      chk("rsvd_oc",   int'(bus_if.o_c), 2);
      chk("rsvd_clk",  int'(bus_if.o_clk), 0);

      // abort while idle is ignored
      abort_at(cyc + 3);
      send(0, 4);
      ts = t0;
      at_cycle(ts + 103);
      chk("idle_abort_err", int'(bus_if.err), 0);
      chk("idle_abort_done", int'(bus_if.done), 1);

      // reset in the middle of HIGH
      send(0, 7);
      ts = t0;
      at_cycle(ts + 20);
      chk("pre_rst_clk", int'(bus_if.o_clk), 1);
      #1 check_en = 0;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_clk",  int'(bus_if.o_clk), 0);
      chk("mid_rst_oc",   int'(bus_if.o_c), 0);
      chk("mid_rst_busy", int'(bus_if.busy), 0);
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      active = 0; prev_oc = 3'd0;
      @(negedge clk);
      chk("post_rst_ready", int'(bus_if.req_ready), 1);
      chk("post_rst_clk",   int'(bus_if.o_clk), 0);
      check_en = 1;
      t_free = cyc;

      send(0, 5);
      ts = t0;
      at_cycle(ts + 1);   chk("final_oc", int'(bus_if.o_c), 5);
      at_cycle(ts + 103); chk("final_done", int'(bus_if.done), 1);
      at_cycle(ts + 106);

      check_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
